// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch
// Purpose  : Operand-fetch stage. It reads the regbank, tracks pending writes
//            in a scoreboard and stalls decode on RAW/WAW hazards.
// Option   : define OPERAND_BYPASS_EN to forward same-cycle writeback data.
// Revision : 1.0  initial release
// ============================================================================
module operand_fetch #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            reset_n,

    input  logic            id_valid_i,
    output logic            id_ready_o,
    input  logic [4:0]      id_rs1_i,
    input  logic [4:0]      id_rs2_i,
    input  logic [4:0]      id_rd_i,
    input  logic            id_we_i,
    input  logic [PC_W-1:0] id_pc_i,

    output logic [4:0]      rf_rs1_o,
    output logic [4:0]      rf_rs2_o,
    input  logic [XLEN-1:0] rf_data1_i,
    input  logic [XLEN-1:0] rf_data2_i,

    input  logic            wb_valid_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,

    input  logic            flush_i,

    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [XLEN-1:0] ex_op1_o,
    output logic [XLEN-1:0] ex_op2_o,
    output logic [4:0]      ex_rd_o,
    output logic            ex_we_o,
    output logic [PC_W-1:0] ex_pc_o
);

    logic [31:0]     sb_q, sb_d;
    logic [31:0]     sb_eff;
    logic [31:0]     clr_mask;

    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_op1_q, ex_op1_d;
    logic [XLEN-1:0] ex_op2_q, ex_op2_d;
    logic [4:0]      ex_rd_q, ex_rd_d;
    logic            ex_we_q, ex_we_d;
    logic [PC_W-1:0] ex_pc_q, ex_pc_d;

    logic            raw, waw, slot_free, issue;
    logic [XLEN-1:0] op1_sel, op2_sel;

    assign rf_rs1_o = id_rs1_i;
    assign rf_rs2_o = id_rs2_i;

    always_comb begin
        clr_mask = '0;
        if (wb_valid_i) begin
            clr_mask[wb_rd_i] = 1'b1;
        end
    end

`ifdef OPERAND_BYPASS_EN
    logic fwd1, fwd2;

    // The register being written this cycle is no longer a hazard: its data is forwarded.
    assign sb_eff = sb_q & ~clr_mask;
    assign fwd1   = wb_valid_i && (wb_rd_i == id_rs1_i) && (id_rs1_i != 5'd0);
    assign fwd2   = wb_valid_i && (wb_rd_i == id_rs2_i) && (id_rs2_i != 5'd0);

    always_comb begin
        op1_sel = rf_data1_i;
        op2_sel = rf_data2_i;
        if (id_rs1_i == 5'd0) begin
            op1_sel = '0;
        end else if (fwd1) begin
            op1_sel = wb_data_i;
        end
        if (id_rs2_i == 5'd0) begin
            op2_sel = '0;
        end else if (fwd2) begin
            op2_sel = wb_data_i;
        end
    end
`else
    logic unused_wb_data;

    assign sb_eff         = sb_q;
    assign unused_wb_data = ^wb_data_i;

    always_comb begin
        op1_sel = rf_data1_i;
        op2_sel = rf_data2_i;
        if (id_rs1_i == 5'd0) begin
            op1_sel = '0;
        end
        if (id_rs2_i == 5'd0) begin
            op2_sel = '0;
        end
    end
`endif

    assign raw = ((id_rs1_i != 5'd0) && sb_eff[id_rs1_i]) ||
                 ((id_rs2_i != 5'd0) && sb_eff[id_rs2_i]);
    assign waw = id_we_i && (id_rd_i != 5'd0) && sb_eff[id_rd_i];

    assign slot_free  = !ex_valid_q || ex_ready_i;
    assign id_ready_o = slot_free && !raw && !waw && !flush_i;
    assign issue      = id_valid_i && id_ready_o;

    // Order matters: a set on issue overrides a same-index writeback clear.
    always_comb begin
        sb_d = sb_q & ~clr_mask;
        if (flush_i && ex_valid_q && ex_we_q) begin
            sb_d[ex_rd_q] = 1'b0;
        end
        if (issue && id_we_i) begin
            sb_d[id_rd_i] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_op1_d   = ex_op1_q;
        ex_op2_d   = ex_op2_q;
        ex_rd_d    = ex_rd_q;
        ex_we_d    = ex_we_q;
        ex_pc_d    = ex_pc_q;
        if (flush_i) begin
            ex_valid_d = 1'b0;
        end else if (issue) begin
            ex_valid_d = 1'b1;
            ex_op1_d   = op1_sel;
            ex_op2_d   = op2_sel;
            ex_rd_d    = id_rd_i;
            ex_we_d    = id_we_i;
            ex_pc_d    = id_pc_i;
        end else if (ex_ready_i) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb_q       <= '0;
            ex_valid_q <= 1'b0;
            ex_op1_q   <= '0;
            ex_op2_q   <= '0;
            ex_rd_q    <= '0;
            ex_we_q    <= 1'b0;
            ex_pc_q    <= '0;
        end else begin
            sb_q       <= sb_d;
            ex_valid_q <= ex_valid_d;
            ex_op1_q   <= ex_op1_d;
            ex_op2_q   <= ex_op2_d;
            ex_rd_q    <= ex_rd_d;
            ex_we_q    <= ex_we_d;
            ex_pc_q    <= ex_pc_d;
        end
    end

    assign ex_valid_o = ex_valid_q;
    assign ex_op1_o   = ex_op1_q;
    assign ex_op2_o   = ex_op2_q;
    assign ex_rd_o    = ex_rd_q;
    assign ex_we_o    = ex_we_q;
    assign ex_pc_o    = ex_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_fetch
// Purpose  : Directed self-checking bench for operand_fetch.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_operand_fetch;

    localparam int XLEN = 32;
    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            id_valid_i, id_ready_o, id_we_i;
    logic [4:0]      id_rs1_i, id_rs2_i, id_rd_i;
    logic [PC_W-1:0] id_pc_i;
    logic [4:0]      rf_rs1_o, rf_rs2_o;
    logic [XLEN-1:0] rf_data1_i, rf_data2_i;
    logic            wb_valid_i;
    logic [4:0]      wb_rd_i;
    logic [XLEN-1:0] wb_data_i;
    logic            flush_i;
    logic            ex_valid_o, ex_ready_i, ex_we_o;
    logic [XLEN-1:0] ex_op1_o, ex_op2_o;
    logic [4:0]      ex_rd_o;
    logic [PC_W-1:0] ex_pc_o;

    int checks = 0;
    int errors = 0;

    operand_fetch #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .id_valid_i (id_valid_i),
        .id_ready_o (id_ready_o),
        .id_rs1_i   (id_rs1_i),
        .id_rs2_i   (id_rs2_i),
        .id_rd_i    (id_rd_i),
        .id_we_i    (id_we_i),
        .id_pc_i    (id_pc_i),
        .rf_rs1_o   (rf_rs1_o),
        .rf_rs2_o   (rf_rs2_o),
        .rf_data1_i (rf_data1_i),
        .rf_data2_i (rf_data2_i),
        .wb_valid_i (wb_valid_i),
        .wb_rd_i    (wb_rd_i),
        .wb_data_i  (wb_data_i),
        .flush_i    (flush_i),
        .ex_valid_o (ex_valid_o),
        .ex_ready_i (ex_ready_i),
        .ex_op1_o   (ex_op1_o),
        .ex_op2_o   (ex_op2_o),
        .ex_rd_o    (ex_rd_o),
        .ex_we_o    (ex_we_o),
        .ex_pc_o    (ex_pc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic we, input logic [PC_W-1:0] pc);
        id_valid_i = v;
        id_rs1_i   = rs1;
        id_rs2_i   = rs2;
        id_rd_i    = rd;
        id_we_i    = we;
        id_pc_i    = pc;
    endtask

    initial begin
        reset_n    = 1'b0;
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, '0);
        rf_data1_i = '0;
        rf_data2_i = '0;
        wb_valid_i = 1'b0;
        wb_rd_i    = '0;
        wb_data_i  = '0;
        flush_i    = 1'b0;
        ex_ready_i = 1'b0;

        #12;
        chk("rst_ex_valid", ex_valid_o, 0);
        chk("rst_ex_op1",   ex_op1_o,   0);
        chk("rst_ex_op2",   ex_op2_o,   0);
        chk("rst_ex_rd",    ex_rd_o,    0);
        chk("rst_ex_we",    ex_we_o,    0);
        chk("rst_ex_pc",    ex_pc_o,    0);
        chk("rst_sb",       dut.sb_q,   0);
        reset_n = 1'b1;
        tick();

        // addi x5, x0, imm : rs1=x0 must read as zero whatever the regbank says
        drive_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 32'h100);
        rf_data1_i = 32'hAAAA;
        rf_data2_i = 32'hBBBB;
        ex_ready_i = 1'b1;
        settle();
        chk("addi_ready", id_ready_o, 1);
        tick();
        id_valid_i = 1'b0;
        chk("addi_ex_valid", ex_valid_o, 1);
        chk("addi_ex_rd",    ex_rd_o,    5);
        chk("addi_ex_op1",   ex_op1_o,   0);
        chk("addi_ex_op2",   ex_op2_o,   0);
        chk("addi_ex_we",    ex_we_o,    1);
        chk("addi_ex_pc",    ex_pc_o,    32'h100);
        chk("addi_sb5",      dut.sb_q[5], 1);

        // RAW on x5
        drive_id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 32'h104);
        rf_data1_i = 32'h1111;
        settle();
        chk("raw_ready0", id_ready_o, 0);
        chk("raw_rf_rs1", rf_rs1_o, 5);
        tick();
        chk("raw_drain", ex_valid_o, 0);
        chk("raw_ready1", id_ready_o, 0);
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd5;
        wb_data_i  = 32'hDEADBEEF;
        settle();
`ifdef OPERAND_BYPASS_EN
        chk("raw_wb_ready", id_ready_o, 1);
        tick();
        wb_valid_i = 1'b0;
`else
        chk("raw_wb_ready", id_ready_o, 0);
        tick();
        wb_valid_i = 1'b0;
        rf_data1_i = 32'hDEADBEEF;
        settle();
        chk("raw_sb5_clr", dut.sb_q[5], 0);
        chk("raw_late_ready", id_ready_o, 1);
        tick();
`endif
        id_valid_i = 1'b0;
        chk("raw_ex_valid", ex_valid_o, 1);
        chk("raw_ex_op1",   ex_op1_o,   32'hDEADBEEF);
        chk("raw_ex_pc",    ex_pc_o,    32'h104);
        chk("raw_sb5",      dut.sb_q[5], 0);
        chk("raw_sb6",      dut.sb_q[6], 1);

        // WAW on x7
        drive_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 32'h108);
        tick();
        chk("waw_sb7_set", dut.sb_q[7], 1);
        drive_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 32'h10C);
        settle();
        chk("waw_ready0", id_ready_o, 0);
        tick();
        chk("waw_ready1", id_ready_o, 0);
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd7;
        wb_data_i  = 32'h7777;
        settle();
`ifdef OPERAND_BYPASS_EN
        chk("waw_wb_ready", id_ready_o, 1);
        tick();
        wb_valid_i = 1'b0;
`else
        chk("waw_wb_ready", id_ready_o, 0);
        tick();
        wb_valid_i = 1'b0;
        settle();
        chk("waw_sb7_clr", dut.sb_q[7], 0);
        chk("waw_late_ready", id_ready_o, 1);
        tick();
`endif
        id_valid_i = 1'b0;
        chk("waw_sb7_final", dut.sb_q[7], 1);
        chk("waw_ex_pc",     ex_pc_o,     32'h10C);
        chk("waw_ex_valid",  ex_valid_o,  1);

        // Hold with execute back-pressured while the regbank changes underneath
        drive_id(1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 32'h110);
        rf_data2_i = 32'h12345678;
        tick();
        ex_ready_i = 1'b0;
        chk("hold_capture", ex_op2_o, 32'h12345678);
        drive_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 32'h114);
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd3;
        wb_data_i  = 32'hCAFE;
        rf_data2_i = 32'hCAFE;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("hold_ready", id_ready_o, 0);
            tick();
            chk("hold_op2",   ex_op2_o,   32'h12345678);
            chk("hold_pc",    ex_pc_o,    32'h110);
            chk("hold_valid", ex_valid_o, 1);
        end
        wb_valid_i = 1'b0;
        id_valid_i = 1'b0;
        ex_ready_i = 1'b1;
        tick();
        chk("drain_valid", ex_valid_o, 0);
        chk("drain_op2",   ex_op2_o,   32'h12345678);

        // Flush of a held writer returns its scoreboard bit
        ex_ready_i = 1'b0;
        drive_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 32'h120);
        tick();
        id_valid_i = 1'b0;
        chk("flush_held",  ex_valid_o,  1);
        chk("flush_sb9",   dut.sb_q[9], 1);
        flush_i = 1'b1;
        drive_id(1'b1, 5'd0, 5'd0, 5'd11, 1'b0, 32'h124);
        settle();
        chk("flush_ready", id_ready_o, 0);
        tick();
        flush_i = 1'b0;
        chk("flush_valid", ex_valid_o,  0);
        chk("flush_sb9c",  dut.sb_q[9], 0);
        drive_id(1'b1, 5'd9, 5'd0, 5'd10, 1'b0, 32'h128);
        rf_data1_i = 32'h99;
        ex_ready_i = 1'b1;
        settle();
        chk("post_flush_ready", id_ready_o, 1);
        tick();
        chk("post_flush_valid", ex_valid_o, 1);
        chk("post_flush_op1",   ex_op1_o,   32'h99);
        chk("post_flush_pc",    ex_pc_o,    32'h128);

        // Writeback to x0 never forwards and never disturbs the scoreboard
        drive_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 32'h130);
        rf_data1_i = 32'h5555;
        rf_data2_i = 32'h6666;
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd0;
        wb_data_i  = 32'hFFFFFFFF;
        settle();
        chk("x0_ready", id_ready_o, 1);
        tick();
        wb_valid_i = 1'b0;
        id_valid_i = 1'b0;
        chk("x0_op1", ex_op1_o, 0);
        chk("x0_op2", ex_op2_o, 0);
        chk("x0_sb",  dut.sb_q, 32'h0000_00C0);

        // Asynchronous reset mid-operation
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", ex_valid_o, 0);
        chk("arst_sb",    dut.sb_q,   0);
        chk("arst_pc",    ex_pc_o,    0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
